// File: rtl/forward_unit.sv
// forward_unit: EX-stage operand forwarding select generator for the 16-bit core.
// Compares the EX source fields against the MEM/WB destination fields and drives
// the operand mux selects (00 = register file, 01 = MEM result, 10 = WB result).
// Optional macro FORWARD_REG_OUT_EN registers haz1/haz2 on clk with async
// active-high rst; without it the outputs are purely combinational.
module forward_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst_ex,
    input  logic [15:0] inst_m,
    input  logic [15:0] inst_wb,
    output logic [1:0]  haz1,
    output logic [1:0]  haz2
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned REG_W = 4;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
    localparam logic [SEL_W-1:0] SEL_WB  = 2'b10;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;

    logic [OP_W-1:0]  ex_op, m_op, wb_op;
    logic [REG_W-1:0] ex_r1, ex_r2, m_r1, wb_r1;
    logic             ex_reads, m_writes, wb_writes;
    logic [SEL_W-1:0] haz1_c, haz2_c;
    logic             unused_bits;

    assign ex_op = inst_ex[15:12];
    assign m_op  = inst_m[15:12];
    assign wb_op = inst_wb[15:12];
    assign ex_r1 = inst_ex[11:8];
    assign ex_r2 = inst_ex[7:4];
    assign m_r1  = inst_m[11:8];
    assign wb_r1 = inst_wb[11:8];

    // Any non-NOP opcode reads r1/r2 and writes r1.
    assign ex_reads  = (ex_op != OP_NOP);
    assign m_writes  = (m_op  != OP_NOP);
    assign wb_writes = (wb_op != OP_NOP);

    // Fields that never take part in forwarding (low nibble, MEM/WB r2, and
    // clk/rst in the combinational build).
    assign unused_bits = ^{clk, rst, inst_ex[3:0], inst_m[7:0], inst_wb[7:0]};

    // Select per operand; MEM wins over WB because it holds the younger value.
    always_comb begin
        haz1_c = SEL_RF;
        haz2_c = SEL_RF;
        if (ex_reads) begin
            if (m_writes && (m_r1 == ex_r1)) begin
                haz1_c = SEL_MEM;
            end else if (wb_writes && (wb_r1 == ex_r1)) begin
                haz1_c = SEL_WB;
            end
            if (m_writes && (m_r1 == ex_r2)) begin
                haz2_c = SEL_MEM;
            end else if (wb_writes && (wb_r1 == ex_r2)) begin
                haz2_c = SEL_WB;
            end
        end
    end

`ifdef FORWARD_REG_OUT_EN
    // Registered selects; reset clears them immediately and drops pending values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haz1 <= SEL_RF;
            haz2 <= SEL_RF;
        end else begin
            haz1 <= haz1_c;
            haz2 <= haz2_c;
        end
    end
`else
    assign haz1 = haz1_c;
    assign haz2 = haz2_c;
`endif

endmodule

// File: tb/tb_forward_unit.sv
// tb_forward_unit: directed and randomized checks of forward_unit against a
// stage-list reference model. Handles both builds (FORWARD_REG_OUT_EN or not).
`timescale 1ns/1ps
module tb_forward_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inst_ex = 16'h0000;
    logic [15:0] inst_m  = 16'h0000;
    logic [15:0] inst_wb = 16'h0000;
    logic [1:0]  haz1, haz2;

    int checks   = 0;
    int failures = 0;

    forward_unit dut (
        .clk     (clk),
        .rst     (rst),
        .inst_ex (inst_ex),
        .inst_m  (inst_m),
        .inst_wb (inst_wb),
        .haz1    (haz1),
        .haz2    (haz2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Reference: walk producers youngest-first (MEM then WB); the first
    // writing stage whose destination equals the source supplies the value.
    // Result is the stage's select code (MEM=1, WB=2), or 0 for the register file.
    function automatic logic [1:0] ref_sel(input logic [15:0] ex, input logic [15:0] m,
                                           input logic [15:0] wb, input int which);
        logic [15:0] stages [2];
        int src;
        stages[0] = m;
        stages[1] = wb;
        if (ex[15:12] == 0) return 2'd0;
        src = (which == 1) ? int'(ex[11:8]) : int'(ex[7:4]);
        for (int s = 0; s < 2; s++) begin
            if (stages[s][15:12] != 0 && int'(stages[s][11:8]) == src)
                return 2'(s + 1);
        end
        return 2'd0;
    endfunction

    logic [1:0] prev1 = 2'b00, prev2 = 2'b00;

    // Drive one vector and check it; in the registered build also check the
    // old value holds until the next rising edge.
    task automatic apply(input string tag, input logic [15:0] ex, input logic [15:0] m,
                         input logic [15:0] wb);
        logic [1:0] e1, e2;
        e1 = ref_sel(ex, m, wb, 1);
        e2 = ref_sel(ex, m, wb, 2);
        @(negedge clk);
        inst_ex = ex;
        inst_m  = m;
        inst_wb = wb;
`ifdef FORWARD_REG_OUT_EN
        #1;
        check({tag, "_hold1"}, haz1, prev1);
        check({tag, "_hold2"}, haz2, prev2);
        @(posedge clk);
        #1;
`else
        #1;
`endif
        check({tag, "_haz1"}, haz1, e1);
        check({tag, "_haz2"}, haz2, e2);
        prev1 = e1;
        prev2 = e2;
    endtask

    function automatic logic [15:0] rand_inst();
        logic [3:0] op;
        op = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        // Small register pool so matches happen often.
        return {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
    endfunction

    initial begin
        #2;
        check("reset_haz1", haz1, 2'b00);
        check("reset_haz2", haz2, 2'b00);
        #10;
        rst = 1'b0;

        apply("all_nop",   16'h0000, 16'h0000, 16'h0000);
        apply("op2_mem",   16'hF010, 16'hF100, 16'hF7A0);
        apply("mem_wb",    16'hF570, 16'hF590, 16'hF7A0);
        apply("ex_nop",    16'h0000, 16'hF000, 16'hF040);
        apply("prio_both", 16'hF330, 16'hF300, 16'hF300);
        apply("mem_nop",   16'hF120, 16'h0100, 16'hF100);
        apply("both_nop",  16'hF120, 16'h0100, 16'h0200);
        apply("reg0",      16'h1000, 16'h2000, 16'h3000);

        // Reset pulse between edges.
        apply("pre_rst",   16'hF570, 16'hF590, 16'hF7A0);
        @(negedge clk);
        rst = 1'b1;
        #1;
`ifdef FORWARD_REG_OUT_EN
        check("rst_async_haz1", haz1, 2'b00);
        check("rst_async_haz2", haz2, 2'b00);
        @(posedge clk);
        #1;
        check("rst_held_haz1", haz1, 2'b00);
        check("rst_held_haz2", haz2, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        prev1 = 2'b00;
        prev2 = 2'b00;
`else
        check("rst_ignored_haz1", haz1, 2'b01);
        check("rst_ignored_haz2", haz2, 2'b10);
        @(negedge clk);
        rst = 1'b0;
`endif

        for (int i = 0; i < 400; i++) begin
            apply("rand", rand_inst(), rand_inst(), rand_inst());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
